pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised, skid-buffered pipeline stage register for the 8-bit pipelined core. It replaces the fixed-field stage registers between IF/ID/EX/MEM/WB with one generic block. Each instance carries a control bundle and a data bundle across a valid/ready handshake, with synchronous flush and a registered `in_ready`. A bubble presents all-zero control downstream, and a saturating stall counter supports performance debug.

## Interface
Parameters:
- `CTRL_W`, default 24: width of the control bundle. On flush or bubble these bits read as zero, so the all-zero encoding must be a NOP.
- `DATA_W`, default 16: width of the data bundle, e.g. operand A and operand B, 8 bits each.
- `CLEAR_DATA`, default 1: 1 means flush also zeroes stored data; 0 means data registers keep their values on flush.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `flush`  in  1  synchronous flush, e.g. taken branch or hazard squash.
- `in_valid`  in  1  upstream presents an entry.
- `in_ready`  out  1  stage can accept an entry; driven directly from a flop.
- `in_ctrl`  in  CTRL_W  upstream control bundle.
- `in_data`  in  DATA_W  upstream data bundle.
- `out_valid`  out  1  stage holds an entry for downstream.
- `out_ready`  in  1  downstream accepts the entry.
- `out_ctrl`  out  CTRL_W  stored control; forced to 0 whenever `out_valid` = 0.
- `out_data`  out  DATA_W  stored data; not gated by `out_valid`.
- `occupancy`  out  2  number of stored entries: 0, 1 or 2.
- `stall_cnt`  out  CNT_W  count of cycles with `out_valid` & !`out_ready`.

## Operation
- Storage:
  - Main register M drives the outputs.
  - Skid register S catches the entry accepted while downstream stalls.
- Handshake events:
  - Accept = `in_valid` & `in_ready` & !`flush`.
  - Take = `out_valid` & `out_ready`.
- State machine:
  - EMPTY (occupancy 0):
    - accept: M <= in, go to ONE.
    - otherwise: stay in EMPTY.
  - ONE (occupancy 1):
    - accept & take: M <= in, stay in ONE.
    - accept & !take: S <= in, go to TWO.
    - take & !accept: go to EMPTY.
    - neither: hold.
  - TWO (occupancy 2):
    - `in_ready` = 0, so no accept is possible.
    - take: M <= S, go to ONE.
    - otherwise: hold.
- `in_ready` flop: next value = (next state != TWO).
- `out_valid` = (state != EMPTY).
- Flush has priority over every handshake event:
  - Next state is EMPTY.
  - M.ctrl and S.ctrl are cleared to 0.
  - If CLEAR_DATA = 1, M.data and S.data are also cleared to 0.
  - An input presented in the flush cycle is discarded, even if `in_ready` = 1.
  - A take in the flush cycle still counts as a transfer on the downstream side; the downstream is responsible for squashing it.
- Stall counter:
  - Increments when `out_valid` & !`out_ready` & !`flush`.
  - Saturates at 2^CNT_W − 1.
  - Cleared only by `rst`; flush does not clear it.
- Ordering: strict FIFO order. The entry in S always leaves after the entry in M.

## Timing
- Reset values: state EMPTY, M = 0, S = 0, `out_valid` 0, `out_ctrl` 0, `out_data` 0, `in_ready` 1, `occupancy` 0, `stall_cnt` 0.
- Latency: an entry accepted at edge N appears on the outputs, with `out_valid` = 1, after edge N.
- Throughput: one entry per cycle while `out_ready` is continuously 1.
- Stall propagation: `in_ready` falls one cycle after downstream stalls while occupancy is 1. The skid register S absorbs the entry in flight during that cycle, so no entry is lost or duplicated.
- Flush takes effect at the next edge: `out_valid` = 0 and `in_ready` = 1 after that edge.
- Reset asserted mid-transfer: all outputs take their reset values immediately. No entry survives reset.
- Combinational paths: `out_ctrl` = M.ctrl gated by `out_valid`. There is no combinational path from `out_ready` to `in_ready`.

## Test plan
- Streaming:
  - Stimulus: after reset, drive entries ctrl = 1..8 and data = 0x0101·k, with `out_ready` = 1 throughout.
  - Required: each entry appears exactly one cycle later, in order; `occupancy` stays 1; `stall_cnt` stays 0.
- Skid fill:
  - Stimulus: feed ctrl = 5, then 6, with `out_ready` = 0.
  - Required: `occupancy` reaches 2 and `in_ready` drops to 0. After `out_ready` = 1, entries 5 then 6 are taken on consecutive cycles, and `in_ready` returns to 1 after entry 5 is taken.
- Flush:
  - Stimulus: with occupancy 2 and `in_valid` = 1 holding ctrl = 9, pulse `flush` for one cycle.
  - Required: next cycle `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0 when CLEAR_DATA = 1, and entry 9 is never emitted.
- CLEAR_DATA = 0:
  - Stimulus: same flush scenario as above.
  - Required: `out_data` retains its pre-flush value while `out_ctrl` = 0.
- Stall counter:
  - Stimulus: with CNT_W = 3, hold one entry stalled for 10 cycles.
  - Required: `stall_cnt` saturates at 7 and stays at 7 after the stall ends and after a flush.
- Asynchronous reset:
  - Stimulus: assert `rst` mid-cycle while occupancy is 2.
  - Required: `out_valid` = 0, `in_ready` = 1 and `occupancy` = 0 before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Generic skid-buffered pipeline stage register for the 8-bit core. It carries
// a control bundle and a data bundle across a valid/ready handshake. It holds
// up to two entries: the main register M drives the outputs, and the skid
// register S catches the entry that is in flight when downstream stalls.
//
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   flush        synchronous squash; empties the stage and drops the input
//   in_valid     upstream presents an entry
//   in_ready     stage can accept an entry (registered output)
//   in_ctrl      upstream control bundle
//   in_data      upstream data bundle
//   out_valid    stage holds an entry for downstream
//   out_ready    downstream accepts the entry
//   out_ctrl     stored control, forced to zero (NOP) while out_valid is 0
//   out_data     stored data, not gated by out_valid
//   occupancy    number of stored entries (0..2)
//   stall_cnt    saturating count of cycles with out_valid & !out_ready
module pipe_stage_skid #(
    parameter int CTRL_W     = 24,
    parameter int DATA_W     = 16,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              rdy_q;
    logic [CTRL_W-1:0] m_ctrl_p1, s_ctrl_p1;
    logic [DATA_W-1:0] m_data_p1, s_data_p1;
    logic [CNT_W-1:0]  stall_q;

    logic vld_p1;
    logic accept;
    logic take;
    logic load_m_in;
    logic load_s_in;
    logic load_m_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    assign vld_p1 = (state_q != EMPTY);
    assign accept = in_valid & rdy_q & ~flush;
    assign take   = vld_p1 & out_ready;

    always_comb begin
        state_d   = state_q;
        load_m_in = 1'b0;
        load_s_in = 1'b0;
        load_m_s  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_m_in = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && take) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    load_s_in = 1'b1;
                    state_d   = TWO;
                end else if (take) begin
                    state_d   = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only a take can move the state.
                if (take) begin
                    load_m_s = 1'b1;
                    state_d  = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush overrides every handshake; register clearing is done below.
        if (flush) begin
            state_d   = EMPTY;
            load_m_in = 1'b0;
            load_s_in = 1'b0;
            load_m_s  = 1'b0;
        end
    end

    // ---- stage boundary: control state, in_ready flop, stall counter ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            // Registered so that out_ready has no combinational path to in_ready.
            rdy_q   <= (state_d != TWO);
            if (vld_p1 && !out_ready && !flush) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

    // ---- stage boundary: M and S payload registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ctrl_p1 <= '0;
            m_data_p1 <= '0;
            s_ctrl_p1 <= '0;
            s_data_p1 <= '0;
        end else if (flush) begin
            m_ctrl_p1 <= '0;
            s_ctrl_p1 <= '0;
            if (CLEAR_DATA) begin
                m_data_p1 <= '0;
                s_data_p1 <= '0;
            end
        end else begin
            if (load_m_in) begin
                m_ctrl_p1 <= in_ctrl;
                m_data_p1 <= in_data;
            end else if (load_m_s) begin
                m_ctrl_p1 <= s_ctrl_p1;
                m_data_p1 <= s_data_p1;
            end
            if (load_s_in) begin
                s_ctrl_p1 <= in_ctrl;
                s_data_p1 <= in_data;
            end
        end
    end

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_p1;
    assign out_ctrl  = vld_p1 ? m_ctrl_p1 : '0;
    assign out_data  = m_data_p1;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid. Two instances share one stimulus stream: dut0
// uses the defaults (CLEAR_DATA=1, CNT_W=16), dut1 uses CLEAR_DATA=0, CNT_W=3.
// Expected values come from a queue-based model of the stage.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] in_ctrl = '0;
    logic [15:0] in_data = '0;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [23:0] out_ctrl0, out_ctrl1;
    logic [15:0] out_data0, out_data1;
    logic [1:0]  occ0, occ1;
    logic [15:0] stall0;
    logic [2:0]  stall1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(24), .DATA_W(16), .CLEAR_DATA(1'b1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occ0), .stall_cnt(stall0)
    );

    pipe_stage_skid #(.CTRL_W(24), .DATA_W(16), .CLEAR_DATA(1'b0), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .occupancy(occ1), .stall_cnt(stall1)
    );

    // Reference model: FIFO of up to two entries plus the observable side state.
    typedef struct packed {
        logic [23:0] c;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_rdy = 1'b1;
    logic [15:0] m_hold0 = '0;   // value M.data shows (CLEAR_DATA=1)
    logic [15:0] m_hold1 = '0;   // value M.data shows (CLEAR_DATA=0)
    int          m_stall0 = 0;
    int          m_stall1 = 0;

    task automatic model_reset();
        q.delete();
        m_rdy    = 1'b1;
        m_hold0  = '0;
        m_hold1  = '0;
        m_stall0 = 0;
        m_stall1 = 0;
    endtask

    task automatic model_edge();
        bit   acc;
        bit   tk;
        ent_t e;
        acc = in_valid && m_rdy && !flush;
        tk  = (q.size() != 0) && out_ready;
        if ((q.size() != 0) && !out_ready && !flush) begin
            if (m_stall0 < 65535) m_stall0++;
            if (m_stall1 < 7)     m_stall1++;
        end
        if (flush) begin
            q.delete();
            m_hold0 = '0;
        end else begin
            if (tk) e = q.pop_front();
            if (acc) begin
                e.c = in_ctrl;
                e.d = in_data;
                q.push_back(e);
            end
        end
        if (q.size() != 0) begin
            m_hold0 = q[0].d;
            m_hold1 = q[0].d;
        end
        m_rdy = (q.size() != 2);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [23:0] ec;
        logic        ev;
        ev = (q.size() != 0);
        ec = ev ? q[0].c : 24'd0;
        chk("d0_out_valid", 32'(out_valid0), 32'(ev));
        chk("d1_out_valid", 32'(out_valid1), 32'(ev));
        chk("d0_in_ready",  32'(in_ready0),  32'(m_rdy));
        chk("d1_in_ready",  32'(in_ready1),  32'(m_rdy));
        chk("d0_occupancy", 32'(occ0),       32'(q.size()));
        chk("d1_occupancy", 32'(occ1),       32'(q.size()));
        chk("d0_out_ctrl",  32'(out_ctrl0),  32'(ec));
        chk("d1_out_ctrl",  32'(out_ctrl1),  32'(ec));
        chk("d0_out_data",  32'(out_data0),  32'(m_hold0));
        chk("d1_out_data",  32'(out_data1),  32'(m_hold1));
        chk("d0_stall_cnt", 32'(stall0),     32'(m_stall0));
        chk("d1_stall_cnt", 32'(stall1),     32'(m_stall1));
    endtask

    // One clock: update the model with the inputs held across the edge, then
    // check all outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input logic [23:0] c, input logic [15:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        logic [31:0] r;

        // Reset state
        tick();
        rst = 1'b0;
        tick();

        // Streaming: ctrl 1..8, data 0x0101*k, out_ready held high
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 24'(k), 16'(16'h0101 * k));
            tick();
            chk("stream_ctrl", 32'(out_ctrl0), 32'(k));
            chk("stream_occ",  32'(occ0), 32'd1);
        end
        drive(1'b0, 24'd0, 16'd0);
        tick();

        // Stall counter: one entry held for 10 cycles
        out_ready = 1'b0;
        drive(1'b1, 24'h11, 16'h1111);
        tick();
        drive(1'b0, 24'd0, 16'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_sat_cnt3", 32'(stall1), 32'd7);
        out_ready = 1'b1;
        tick();
        chk("stall_hold_after", 32'(stall1), 32'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stall_hold_flush", 32'(stall1), 32'd7);

        // Skid fill: 5 then 6 with downstream stalled, then release
        out_ready = 1'b0;
        drive(1'b1, 24'd5, 16'h0505);
        tick();
        drive(1'b1, 24'd6, 16'h0606);
        tick();
        chk("skid_occ2", 32'(occ0), 32'd2);
        chk("skid_rdy0", 32'(in_ready0), 32'd0);
        drive(1'b0, 24'd0, 16'd0);
        tick();
        out_ready = 1'b1;
        tick();
        chk("skid_second", 32'(out_ctrl0), 32'd6);
        chk("skid_rdy_back", 32'(in_ready0), 32'd1);
        tick();

        // Flush at occupancy 2 with entry 9 presented
        out_ready = 1'b0;
        drive(1'b1, 24'd7, 16'h0707);
        tick();
        drive(1'b1, 24'd8, 16'h0808);
        tick();
        drive(1'b1, 24'd9, 16'h0909);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_clr_data", 32'(out_data0), 32'd0);
        chk("flush_keep_data", 32'(out_data1), 32'h0707);
        chk("flush_ctrl_zero", 32'(out_ctrl1), 32'd0);
        drive(1'b0, 24'd0, 16'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_no_emit", 32'(out_valid0), 32'd0);
        end

        // Flush while in_ready=1: presented entry must be discarded
        drive(1'b1, 24'h0a, 16'h0a0a);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 24'd0, 16'd0);
        tick();

        // Asynchronous reset mid-cycle at occupancy 2
        out_ready = 1'b0;
        drive(1'b1, 24'h21, 16'h2121);
        tick();
        drive(1'b1, 24'h22, 16'h2222);
        tick();
        drive(1'b0, 24'd0, 16'd0);
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_valid", 32'(out_valid0), 32'd0);
        chk("arst_ready", 32'(in_ready0), 32'd1);
        chk("arst_occ",   32'(occ0), 32'd0);
        compare_all();
        #1;
        rst = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            in_valid  = r[0] | r[1];
            out_ready = r[2] | (r[3] & r[4]);
            flush     = (r[12:8] == 5'd0);
            r = $urandom();
            in_ctrl = r[23:0];
            r = $urandom();
            in_data = r[15:0];
            tick();
        end
        drive(1'b0, 24'd0, 16'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
